// File: rtl/bus_txn_sequencer_pkg.sv
// Shared encodings for the bus transaction sequencer: burst modes and FSM states.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    MODE_READ   = 2'b00,
    MODE_WRITE  = 2'b01,
    MODE_VERIFY = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_WAIT,
    S_NEXT,
    S_PHASE2,
    S_DONE
  } state_e;

  // Write and verify bursts both open with a write phase; reserved falls back to read.
  function automatic logic is_write_mode(input logic [1:0] m);
    return (m == MODE_WRITE) || (m == MODE_VERIFY);
  endfunction

endpackage

// File: rtl/bus_txn_sequencer_if.sv
// Request/response port toward the system-bus master device.
interface bus_txn_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_mode;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport master (
    output m_addr, m_wdata, m_mode, m_valid,
    input  m_ready, m_rdata
  );

  modport slave (
    input  m_addr, m_wdata, m_mode, m_valid,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/bus_txn_sequencer_buf.sv
// Write-data preload buffer and read-data capture buffer, both with async read ports.
module seq_dual_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 32,
  parameter int IDX_W      = $clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  load_en,
  input  logic [IDX_W-1:0]      load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  cap_en,
  input  logic [IDX_W-1:0]      cap_addr,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic [IDX_W-1:0]      fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic [IDX_W-1:0]      dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data
);

  logic [DATA_WIDTH-1:0] wbuf [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] rbuf [BUF_DEPTH];

  // Preload port for outgoing write data
  always_ff @(posedge clk) begin
    if (load_en) wbuf[load_addr] <= load_data;
  end

  // Capture port for returned read data
  always_ff @(posedge clk) begin
    if (cap_en) rbuf[cap_addr] <= cap_data;
  end

  assign fetch_data = wbuf[fetch_addr];
  assign dump_data  = rbuf[dump_addr];

endmodule

// File: rtl/bus_txn_sequencer.sv
// Burst traffic driver: runs N read/write/verify transactions at consecutive addresses.
module bus_txn_sequencer
  import bus_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int BUF_DEPTH      = 32,
  parameter int CNT_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [CNT_WIDTH-1:0]         txn_count,
  input  logic                         load_en,
  input  logic [$clog2(BUF_DEPTH)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data,
  input  logic [$clog2(BUF_DEPTH)-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0]        dump_data,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [ERR_WIDTH-1:0]         err_count,
  output logic [CNT_WIDTH-1:0]         first_err_idx,
  bus_txn_sequencer_if.master          m
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q;
  logic                  start_q;
  logic                  wr_q;
  logic                  verify_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  idx_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [ERR_WIDTH-1:0]  err_q;
  logic [CNT_WIDTH-1:0]  first_q;
  logic                  timeout_q;
  logic                  done_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  start_edge;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [CNT_WIDTH-1:0]  idx_d;
  logic                  tmo_hit;
  logic                  cap_en;
  logic                  cmp_miss;
  logic [DATA_WIDTH-1:0] fetch_data;

  assign start_edge = start & ~start_q;
  assign cnt_d      = (txn_count > CNT_WIDTH'(BUF_DEPTH)) ? CNT_WIDTH'(BUF_DEPTH) : txn_count;
  assign idx_d      = idx_q + 1'b1;
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign cap_en     = (state_q == S_WAIT) && m.m_ready && !wr_q;
  assign cmp_miss   = verify_q && !wr_q && (m.m_rdata != fetch_data);

  seq_dual_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk        (clk),
    .load_en    (load_en && (state_q == S_IDLE)),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .cap_en     (cap_en),
    .cap_addr   (idx_q[IDX_W-1:0]),
    .cap_data   (m.m_rdata),
    .fetch_addr (idx_q[IDX_W-1:0]),
    .fetch_data (fetch_data),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

  // Burst sequencing FSM with registered bus-side outputs, timeout and verify counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      wr_q      <= 1'b0;
      verify_q  <= 1'b0;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      first_q   <= '1;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            wr_q      <= is_write_mode(mode);
            verify_q  <= (mode == MODE_VERIFY);
            base_q    <= base_addr;
            cnt_q     <= cnt_d;
            idx_q     <= '0;
            err_q     <= '0;
            first_q   <= '1;
            timeout_q <= 1'b0;
            if (cnt_d == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (m.m_ready) begin
            valid_q <= 1'b1;
            addr_q  <= base_q + ADDR_WIDTH'(idx_q);
            wdata_q <= fetch_data;
            tmo_q   <= '0;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          if (!m.m_ready) begin
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (m.m_ready) begin
            if (cmp_miss) begin
              if (err_q != '1) err_q <= err_q + 1'b1;
              if (err_q == '0) first_q <= idx_q;
            end
            state_q <= S_NEXT;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_NEXT: begin
          idx_q <= idx_d;
          if (idx_d == cnt_q) begin
            if (verify_q && wr_q) begin
              state_q <= S_PHASE2;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_PHASE2: begin
          idx_q   <= '0;
          wr_q    <= 1'b0;
          state_q <= S_ISSUE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready         = (state_q == S_IDLE);
  assign busy          = ~ready;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign m.m_addr      = addr_q;
  assign m.m_wdata     = wdata_q;
  assign m.m_mode      = wr_q;
  assign m.m_valid     = valid_q;

endmodule

// File: tb/tb_bus_txn_sequencer.sv
// Directed, table-driven bench for bus_txn_sequencer with a behavioural bus slave.
module tb_bus_txn_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] base_addr = '0;
  logic [5:0]  txn_count = '0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [7:0]  load_data = '0;
  logic [4:0]  dump_addr = '0;
  logic [7:0]  dump_data;
  logic        ready, busy, done, timeout;
  logic [7:0]  err_count;
  logic [5:0]  first_err_idx;

  bus_txn_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  bus_txn_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .BUF_DEPTH(32), .CNT_WIDTH(6),
    .TIMEOUT_CYCLES(1024), .ERR_WIDTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .base_addr(base_addr),
    .txn_count(txn_count), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .dump_addr(dump_addr), .dump_data(dump_data),
    .ready(ready), .busy(busy), .done(done), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx), .m(bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural slave: memory, latency, hang and single-read corruption controls
  logic [7:0]  smem [0:65535];
  logic [15:0] pl_addr [$];
  logic [7:0]  pl_wd [$];
  logic        pl_mode [$];
  int          lat = 1;
  bit          hang = 0;
  int          corrupt = -1;
  int          rd_n = 0;
  int          done_cnt = 0;
  logic [15:0] s_addr;
  logic [7:0]  s_wd;
  logic        s_md;

  initial begin
    bus.m_ready = 1'b1;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        s_addr = bus.m_addr;
        s_wd   = bus.m_wdata;
        s_md   = bus.m_mode;
        pl_addr.push_back(s_addr);
        pl_wd.push_back(s_wd);
        pl_mode.push_back(s_md);
        bus.m_ready = 1'b0;
        repeat (lat) @(negedge clk);
        while (hang) @(negedge clk);
        if (s_md) begin
          smem[s_addr] = s_wd;
        end else begin
          bus.m_rdata = (rd_n == corrupt) ? 8'hFF : smem[s_addr];
          rd_n++;
        end
        bus.m_ready = 1'b1;
      end
    end
  end

  // Counts done pulses
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] base;
    logic [5:0]  cnt;
    int          corrupt;
    int          plen;
    int          nwr;
    int          pulses;
    logic [15:0] addr_last;
    logic [7:0]  err;
    logic [5:0]  first;
    bit          chk_dump;
    logic [7:0]  dump0;
    logic [7:0]  dump1;
  } vec_t;

  vec_t       vt [8];
  logic [7:0] pre [32];

  task automatic clear_log();
    pl_addr.delete();
    pl_wd.delete();
    pl_mode.delete();
    done_cnt = 0;
    rd_n = 0;
  endtask

  // Starts a burst and waits (bounded) for its done pulse; returns cycles spent
  task automatic run_burst(input logic [1:0] md, input logic [15:0] b, input logic [5:0] c,
                           input int bound, input string nm, output int cyc);
    clear_log();
    @(negedge clk);
    mode = md; base_addr = b; txn_count = c; start = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    if (done_cnt == 0) chk({nm, "_done_wait"}, 32'(done_cnt), 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int bad_a, bad_m, bad_w;
    string nm;

    for (int i = 0; i < 32; i++) pre[i] = (i < 4) ? 8'(8'hA0 + i) : 8'(8'h10 + i);
    smem[16'h2000] = 8'h5A;
    smem[16'h2001] = 8'h5B;

    vt[0] = '{2'b01, 16'h1001, 6'd4,  -1, 4,  4,  4,  16'h1004, 8'd0, 6'h3F, 0, 8'h00, 8'h00};
    vt[1] = '{2'b00, 16'h2000, 6'd2,  -1, 2,  0,  2,  16'h2001, 8'd0, 6'h3F, 1, 8'h5A, 8'h5B};
    vt[2] = '{2'b10, 16'h3000, 6'd4,   2, 4,  4,  8,  16'h3003, 8'd1, 6'd2,  1, 8'hA0, 8'hA1};
    vt[3] = '{2'b01, 16'hFFFF, 6'd2,  -1, 2,  2,  2,  16'h0000, 8'd0, 6'h3F, 0, 8'h00, 8'h00};
    vt[4] = '{2'b01, 16'h8000, 6'd0,  -1, 0,  0,  0,  16'h0000, 8'd0, 6'h3F, 0, 8'h00, 8'h00};
    vt[5] = '{2'b01, 16'h4000, 6'd40, -1, 32, 32, 32, 16'h401F, 8'd0, 6'h3F, 0, 8'h00, 8'h00};
    vt[6] = '{2'b11, 16'h2000, 6'd2,  -1, 2,  0,  2,  16'h2001, 8'd0, 6'h3F, 1, 8'h5A, 8'h5B};
    vt[7] = '{2'b10, 16'h5000, 6'd3,  -1, 3,  3,  6,  16'h5002, 8'd0, 6'h3F, 1, 8'hA0, 8'hA1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_first", 32'(first_err_idx), 32'h3F);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_mode", 32'(bus.m_mode), 32'd0);
    chk("rst_addr", 32'(bus.m_addr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Preload write buffer
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = 5'(i); load_data = pre[i];
    end
    @(negedge clk);
    load_en = 1'b0;

    // Table-driven bursts
    for (int k = 0; k < 8; k++) begin
      nm = $sformatf("v%0d", k);
      corrupt = vt[k].corrupt;
      run_burst(vt[k].mode, vt[k].base, vt[k].cnt, 1200, nm, cyc);
      chk({nm, "_pulses"}, 32'(pl_addr.size()), 32'(vt[k].pulses));
      chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
      bad_a = 0; bad_m = 0; bad_w = 0;
      for (int i = 0; i < pl_addr.size(); i++) begin
        if (pl_addr[i] !== 16'(vt[k].base + 16'(i % vt[k].plen))) bad_a++;
        if (pl_mode[i] !== logic'(i < vt[k].nwr)) bad_m++;
        if (i < vt[k].nwr && pl_wd[i] !== pre[i]) bad_w++;
      end
      chk({nm, "_addr_seq_bad"}, 32'(bad_a), 32'd0);
      chk({nm, "_mode_seq_bad"}, 32'(bad_m), 32'd0);
      chk({nm, "_wdata_bad"}, 32'(bad_w), 32'd0);
      if (pl_addr.size() > 0) chk({nm, "_addr_last"}, 32'(pl_addr[pl_addr.size()-1]), 32'(vt[k].addr_last));
      chk({nm, "_err"}, 32'(err_count), 32'(vt[k].err));
      chk({nm, "_first"}, 32'(first_err_idx), 32'(vt[k].first));
      chk({nm, "_timeout"}, 32'(timeout), 32'd0);
      chk({nm, "_ready"}, 32'(ready), 32'd1);
      if (vt[k].chk_dump) begin
        dump_addr = 5'd0; #1;
        chk({nm, "_dump0"}, 32'(dump_data), 32'(vt[k].dump0));
        dump_addr = 5'd1; #1;
        chk({nm, "_dump1"}, 32'(dump_data), 32'(vt[k].dump1));
      end
    end
    corrupt = -1;

    // Count 0: done in the cycle after the accepting edge, no bus activity
    clear_log();
    @(negedge clk);
    mode = 2'b01; base_addr = 16'h9000; txn_count = 6'd0; start = 1'b1;
    @(negedge clk);
    chk("cnt0_done_lat", 32'(done), 32'd1);
    @(negedge clk);
    chk("cnt0_done_drop", 32'(done), 32'd0);
    chk("cnt0_ready", 32'(ready), 32'd1);
    chk("cnt0_pulses", 32'(pl_addr.size()), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Start edge and load while busy are both ignored
    clear_log();
    @(negedge clk);
    mode = 2'b01; base_addr = 16'h7000; txn_count = 6'd4; start = 1'b1;
    repeat (3) @(negedge clk);
    load_en = 1'b1; load_addr = 5'd3; load_data = 8'h77;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (12) @(negedge clk);
    chk("midedge_pulses", 32'(pl_addr.size()), 32'd4);
    chk("midedge_done_cnt", 32'(done_cnt), 32'd1);
    chk("midedge_ready", 32'(ready), 32'd1);
    if (pl_wd.size() == 4) chk("busy_load_ignored", 32'(pl_wd[3]), 32'(pre[3]));
    else chk("busy_load_pulses", 32'(pl_wd.size()), 32'd4);
    start = 1'b0;
    @(negedge clk);

    // Timeout: slave never completes the first request
    hang = 1;
    run_burst(2'b01, 16'h6000, 6'd2, 1300, "tmo", cyc);
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_window", 32'(cyc >= 1020 && cyc <= 1040), 32'd1);
    chk("tmo_pulses", 32'(pl_addr.size()), 32'd1);
    chk("tmo_done_cnt", 32'(done_cnt), 32'd1);
    chk("tmo_ready", 32'(ready), 32'd1);
    hang = 0;
    repeat (2) @(negedge clk);
    clear_log();
    mode = 2'b01; base_addr = 16'h6100; txn_count = 6'd1; start = 1'b1;
    @(negedge clk);
    chk("tmo_cleared", 32'(timeout), 32'd0);
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_next_done", 32'(done_cnt), 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while waiting on the slave
    lat = 5;
    clear_log();
    @(negedge clk);
    mode = 2'b00; base_addr = 16'h2000; txn_count = 6'd4; start = 1'b1;
    cyc = 0;
    while (pl_addr.size() == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_issued", 32'(pl_addr.size()), 32'd1);
    @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstmid_valid", 32'(bus.m_valid), 32'd0);
    chk("rstmid_ready", 32'(ready), 32'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstmid_no_done", 32'(done_cnt), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_idle", 32'(ready), 32'd1);
    lat = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_txn_sequencer.md
Name: bus_txn_sequencer

Overview:
- Parametrised bus-master traffic driver; sits between a local board-level control (start/mode switches) and the d1 master-device port of the system-bus top.
- On a start edge, runs a programmable burst of N transactions at consecutive bus addresses.
- Modes: read, write, or write-then-verify.
- Write data comes from an internal preload buffer; read data is stored in an internal capture buffer; verify mode counts mismatches.

Parameters:
ADDR_WIDTH, 16, bus address width
DATA_WIDTH, 8, bus data width
BUF_DEPTH, 32, entries in each of the write and capture buffers (power of 2)
CNT_WIDTH, 6, width of txn_count; must hold BUF_DEPTH
TIMEOUT_CYCLES, 1024, max cycles waiting on m_ready before abort
ERR_WIDTH, 8, error counter width

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
start  in  1  level; rising edge starts a burst
mode  in  2  00 read, 01 write, 10 write-then-verify, 11 reserved (treated as read)
base_addr  in  ADDR_WIDTH  first bus address
txn_count  in  CNT_WIDTH  transactions per burst; values > BUF_DEPTH clamp to BUF_DEPTH
load_en  in  1  write wbuf[load_addr] = load_data (ignored while busy)
load_addr  in  log2(BUF_DEPTH)  preload index
load_data  in  DATA_WIDTH  preload data
dump_addr  in  log2(BUF_DEPTH)  capture-buffer read index
dump_data  out  DATA_WIDTH  rbuf[dump_addr], combinational
ready  out  1  high in IDLE
busy  out  1  ~ready
done  out  1  one-cycle pulse at burst end
timeout  out  1  sticky; set on abort, cleared on next accepted start
err_count  out  ERR_WIDTH  verify mismatches, saturating
first_err_idx  out  CNT_WIDTH  index of first mismatch; all-ones if none
m_addr  out  ADDR_WIDTH  to master device
m_wdata  out  DATA_WIDTH  to master device
m_mode  out  1  0 read, 1 write
m_valid  out  1  request strobe
m_ready  in  1  master idle/complete
m_rdata  in  DATA_WIDTH  read data from master

Behaviour:
- Reset: state IDLE. All outputs 0, except ready=1 and first_err_idx=all-ones. Buffers are not reset. Reset mid-burst aborts immediately with no done pulse.
- start is registered; edge = start & ~start_q. An edge is only accepted in IDLE; edges while busy are ignored.
- On accept: latch mode, base_addr, clamped count; clear index, err_count, first_err_idx and timeout.
  - Count 0: go straight to DONE (done pulses one cycle later, no bus activity).
- States:
  - IDLE
  - ISSUE: wait for m_ready=1, then drive m_valid=1 for exactly 1 cycle with m_addr=base+idx (mod 2^ADDR_WIDTH), m_wdata=wbuf[idx], m_mode.
  - ACK: wait for m_ready=0.
  - WAIT: wait for m_ready=1; on reads, capture m_rdata into rbuf[idx] on that cycle.
  - NEXT: idx+1; if idx+1==count, go to DONE, or PHASE2 in verify mode while still in the write phase; else go to ISSUE.
  - PHASE2: idx=0, m_mode=0; go to ISSUE.
  - DONE: done=1 for 1 cycle; go to IDLE.
- m_addr/m_wdata/m_mode hold stable from ISSUE until WAIT exits.
- Verify: in the read phase, compare m_rdata to wbuf[idx].
  - On mismatch: err_count+1, saturating at all-ones.
  - On the first mismatch, record idx into first_err_idx.
- Timeout: a cycle counter is reset on entry to ACK and to WAIT. If it reaches TIMEOUT_CYCLES, set timeout and go to DONE; done still pulses.
- load_en in the same cycle as an accepted start: the load is performed, since the state is still IDLE that cycle.
- Minimum per-transaction latency: 4 cycles (ISSUE, ACK, WAIT, NEXT) with an ideal master.

Decomposition:
- Shared package bus_seq_pkg: mode encodings (MODE_READ/WRITE/VERIFY) and state enum constants.
- One sub-module, seq_dual_buf: holds wbuf and rbuf, with the load port, capture port, fetch read and dump read.
- FSM, counters and compare logic stay in the top module.

Test Plan:
- Preload wbuf[0..3]=A0,A1,A2,A3; mode=01, base=0x1001, count=4 -> m_valid pulses at addrs 0x1001..0x1004 with data A0..A3, m_mode=1, exactly one done pulse.
- Slave memory returns 5A,5B at 0x2000/0x2001; mode=00, count=2 -> dump_data at idx0=5A and idx1=5B, err_count=0.
- Verify mode, count=4; the model corrupts the read at idx2 to 0xFF -> err_count=1, first_err_idx=2, 8 m_valid pulses total.
- base=0xFFFF, count=2, write -> addrs 0xFFFF then 0x0000.
- Master holds m_ready=0 after the first request -> timeout=1 after 1024 cycles, done pulses, ready returns; next start clears timeout.
- count=0 -> done within 2 cycles, no m_valid. A start edge mid-burst is ignored. Assert rstn mid-WAIT -> m_valid=0, ready=1 immediately, no done.
